// File: rtl/arb4_decoder_ctrl.sv
// Round-robin owner of a shared 2-to-4 decoder: drives sel/en, mirrors grant,
// enforces a hold limit under contention and a one-cycle gap between owners.
module arb4_decoder_ctrl #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic [3:0] req_i,
  output logic [1:0] sel_o,
  output logic       en_o,
  output logic [3:0] grant_o,
  output logic       preempt_o
);

  // state | meaning
  // IDLE  | no owner, decoder disabled
  // GRANT | sel_q owns the decoder, en high, cnt_q counts held cycles
  // GAP   | one dead cycle after a release, sel_q still names the old owner
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_e;

  localparam logic       HOLD_EN   = (MAX_HOLD != 0);
  localparam logic [7:0] HOLD_LAST = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);

  state_e     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] sel_q, sel_d;
  logic       en_q, en_d;
  logic [3:0] grant_q, grant_d;
  logic       preempt_q, preempt_d;

  logic [1:0] win;
  logic       found;
  logic       any_req;
  logic       owner_req;
  logic       others_waiting;
  logic       hold_expired;

  // Search starts just after the last owner, so the last owner ranks lowest.
  always_comb begin
    win   = ptr_q;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      logic [1:0] idx;
      idx = ptr_q + 2'(k);
      if (!found && req_i[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  assign any_req        = |req_i;
  assign owner_req      = req_i[sel_q];
  assign others_waiting = |(req_i & ~(4'b0001 << sel_q));
  assign hold_expired   = HOLD_EN && (cnt_q == HOLD_LAST);

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      ptr_q     <= 2'd3;
      cnt_q     <= 8'd0;
      sel_q     <= 2'd0;
      en_q      <= 1'b0;
      grant_q   <= 4'b0000;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      en_q      <= en_d;
      grant_q   <= grant_d;
      preempt_q <= preempt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = any_req ? GRANT : IDLE;
      GRANT: begin
        if (!owner_req)                         state_d = GAP;
        else if (hold_expired && others_waiting) state_d = GAP;
        else                                     state_d = GRANT;
      end
      GAP:     state_d = any_req ? GRANT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered: this block computes their next values.
  always_comb begin
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    en_d      = 1'b0;
    grant_d   = 4'b0000;
    preempt_d = 1'b0;
    if (state_d == GRANT) begin
      en_d = 1'b1;
      if (state_q != GRANT) begin
        sel_d   = win;
        ptr_d   = win;
        cnt_d   = 8'd0;
        grant_d = 4'b0001 << win;
      end else begin
        grant_d = grant_q;
        if (!hold_expired && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
      end
    end else if (state_q == GRANT) begin
      // Leaving GRANT while the owner still requests can only be a forced release.
      preempt_d = owner_req;
    end
  end

  assign sel_o     = sel_q;
  assign en_o      = en_q;
  assign grant_o   = grant_q;
  assign preempt_o = preempt_q;

endmodule

// File: tb/tb_arb4_decoder_ctrl.sv
// Bench for arb4_decoder_ctrl: directed vector table, hand sequences for
// multi-cycle corners, then randomized traffic against a behavioural model.
module tb_arb4_decoder_ctrl;
  localparam int MH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [1:0] sel;
  logic       en;
  logic [3:0] grant;
  logic       pre;

  always #5 clk = ~clk;

  arb4_decoder_ctrl #(.MAX_HOLD(MH)) dut (
    .clock_i  (clk),
    .reset_i  (rst),
    .req_i    (req),
    .sel_o    (sel),
    .en_o     (en),
    .grant_o  (grant),
    .preempt_o(pre)
  );

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [1:0] sel;
    logic       en;
    logic [3:0] grant;
    logic       pre;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Model: owner index (-1 when none), last owner, en cycles held so far.
  int         m_owner = -1;
  int         m_last  = 3;
  int         m_hold  = 0;
  logic [1:0] m_sel   = 2'd0;
  logic       m_pre   = 1'b0;

  function automatic void add(input logic r, input logic [3:0] rq, input logic [1:0] s,
                              input logic e, input logic [3:0] g, input logic p);
    vec_t v;
    v.rst = r; v.req = rq; v.sel = s; v.en = e; v.grant = g; v.pre = p;
    vecs.push_back(v);
  endfunction

  task automatic model_step(input logic r, input logic [3:0] rq);
    if (r) begin
      m_owner = -1; m_last = 3; m_hold = 0; m_sel = 2'd0; m_pre = 1'b0;
    end else if (m_owner >= 0) begin
      m_pre = 1'b0;
      if (!rq[m_owner]) begin
        m_owner = -1;
      end else if (MH != 0 && m_hold >= MH && (rq & ~(4'b0001 << m_owner)) != 4'b0000) begin
        m_owner = -1;
        m_pre   = 1'b1;
      end else begin
        m_hold++;
      end
    end else begin
      m_pre = 1'b0;
      for (int d = 1; d <= 4; d++) begin
        int c;
        c = (m_last + d) % 4;
        if (rq[c]) begin
          m_owner = c; m_last = c; m_sel = 2'(c); m_hold = 1;
          break;
        end
      end
    end
  endtask

  task automatic tick(input logic r, input logic [3:0] rq);
    @(negedge clk);
    rst = r;
    req = rq;
    @(posedge clk);
    model_step(r, rq);
    #1;
  endtask

  task automatic check(input string name, input int idx, input logic [1:0] es, input logic ee,
                       input logic [3:0] eg, input logic ep);
    n_tests++;
    if (sel !== es || en !== ee || grant !== eg || pre !== ep) begin
      n_fail++;
      $display("FAIL %s[%0d]: got sel=%0d en=%b grant=%b preempt=%b, expected sel=%0d en=%b grant=%b preempt=%b",
               name, idx, sel, en, grant, pre, es, ee, eg, ep);
    end
  endtask

  initial begin
    // Reset held with all requests, then full-load round robin.
    add(1, 4'hF, 0, 0, 4'b0000, 0);
    add(1, 4'hF, 0, 0, 4'b0000, 0);
    for (int o = 0; o < 4; o++) begin
      for (int c = 0; c < MH; c++) add(0, 4'hF, 2'(o), 1, 4'(1 << o), 0);
      add(0, 4'hF, 2'(o), 0, 4'b0000, 1);
    end
    add(0, 4'hF, 0, 1, 4'b0001, 0);
    add(1, 4'h0, 0, 0, 4'b0000, 0);
    // Single owner, normal release.
    for (int c = 0; c < 3; c++) add(0, 4'b0100, 2, 1, 4'b0100, 0);
    add(0, 4'b0000, 2, 0, 4'b0000, 0);
    add(0, 4'b0000, 2, 0, 4'b0000, 0);
    // No contention: hold runs past the limit.
    for (int c = 0; c < 10; c++) add(0, 4'b0010, 1, 1, 4'b0010, 0);
    add(0, 4'b0000, 1, 0, 4'b0000, 0);
    add(0, 4'b0000, 1, 0, 4'b0000, 0);
    // Owner drops exactly when the hold limit would fire.
    for (int c = 0; c < MH; c++) add(0, 4'b0011, 0, 1, 4'b0001, 0);
    add(0, 4'b0010, 0, 0, 4'b0000, 0);
    add(0, 4'b0010, 1, 1, 4'b0010, 0);
    add(0, 4'b0000, 1, 0, 4'b0000, 0);
    add(0, 4'b0000, 1, 0, 4'b0000, 0);
    // Reset in the middle of a grant restarts the pointer.
    add(0, 4'b1000, 3, 1, 4'b1000, 0);
    add(0, 4'b1000, 3, 1, 4'b1000, 0);
    add(1, 4'b1001, 0, 0, 4'b0000, 0);
    add(0, 4'b1001, 0, 1, 4'b0001, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      tick(vecs[i].rst, vecs[i].req);
      check("table", i, vecs[i].sel, vecs[i].en, vecs[i].grant, vecs[i].pre);
    end

    // Saturated hold, then a contender appears: release on the very next edge.
    tick(1, 4'b0000);
    check("sat_reset", 0, 0, 0, 4'b0000, 0);
    for (int c = 0; c < 8; c++) begin
      tick(0, 4'b0010);
      check("sat_hold", c, 1, 1, 4'b0010, 0);
    end
    tick(0, 4'b0011);
    check("sat_preempt", 0, 1, 0, 4'b0000, 1);
    for (int c = 0; c < MH; c++) begin
      tick(0, 4'b0011);
      check("sat_next_owner", c, 0, 1, 4'b0001, 0);
    end
    tick(0, 4'b0011);
    check("sat_second_preempt", 0, 0, 0, 4'b0000, 1);
    tick(0, 4'b0011);
    check("sat_back_to_1", 0, 1, 1, 4'b0010, 0);

    // Sole requester regains the decoder straight after its own gap.
    tick(0, 4'b0000);
    check("regain_gap", 0, 1, 0, 4'b0000, 0);
    tick(0, 4'b0000);
    check("regain_idle", 0, 1, 0, 4'b0000, 0);
    tick(0, 4'b0100);
    check("regain_first", 0, 2, 1, 4'b0100, 0);
    tick(0, 4'b0000);
    check("regain_gap2", 0, 2, 0, 4'b0000, 0);
    tick(0, 4'b0100);
    check("regain_again", 0, 2, 1, 4'b0100, 0);

    // Random sticky requests with rare resets, compared to the model.
    tick(1, 4'b0000);
    check("rand_reset", 0, m_sel, 1'b0, 4'b0000, 1'b0);
    begin
      logic [3:0] rq;
      logic       r;
      rq = 4'b0000;
      for (int n = 0; n < 3000; n++) begin
        for (int b = 0; b < 4; b++)
          if ($urandom_range(0, 5) == 0) rq[b] = ~rq[b];
        r = ($urandom_range(0, 199) == 0);
        tick(r, rq);
        check("random", n, m_sel, (m_owner >= 0),
              (m_owner >= 0) ? 4'(4'b0001 << m_sel) : 4'b0000, m_pre);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/arb4_decoder_ctrl.md
# arb4_decoder_ctrl

Round-robin arbiter and sequencer that shares one 2-to-4 decoder among four requesters. It drives the decoder's `sel[1:0]` and `en` inputs and mirrors the resulting one-hot `grant[3:0]`. Ownership is held while the owner keeps requesting. A hold timer forces release when others are waiting. A mandatory one-cycle gap separates successive owners.

## Interface
- `MAX_HOLD`, 8 — maximum consecutive `en` cycles per owner when another request is pending. 0 disables preemption. Legal range 0..255.
- `clock`  in  1  — single clock; all logic on the rising edge.
- `reset`  in  1  — synchronous, active-high reset.
- `req`  in  4  — level requests; `req[i]` high means requester i wants the decoder.
- `sel`  out  2  — index of the current owner; drives the decoder select.
- `en`  out  1  — high while a grant is active; drives the decoder enable.
- `grant`  out  4  — registered one-hot: `1<<sel` when `en`=1, else 4'b0000.
- `preempt`  out  1  — one-cycle pulse in the gap cycle that follows a forced release.

## Operation
- State machine states: IDLE, GRANT, GAP. Registers: `ptr[1:0]` (last owner), `cnt` (8 bits, saturating).
- Reset values: state IDLE, `sel`=0, `en`=0, `grant`=0, `preempt`=0, `ptr`=3, `cnt`=0. With `ptr`=3, requester 0 wins first.
- Arbitration search order: `ptr+1`, `ptr+2`, `ptr+3`, `ptr` (mod 4). The first set `req` bit wins. On entry to GRANT: `sel`=winner, `ptr`=winner, `cnt`=0.
- IDLE:
  - Any `req` set -> GRANT.
  - Otherwise stay in IDLE with `en`=0.
- GRANT:
  - `en`=1 and `cnt` increments each cycle.
  - `req[sel]`=0 -> GAP. This is a normal release: `preempt`=0.
  - Else, if `MAX_HOLD`≠0, `cnt`==`MAX_HOLD`-1, and any other `req` bit is set -> GAP. This is a forced release: `preempt`=1 during the GAP cycle.
  - Else, if `cnt` reaches the limit and no other requester is waiting, the grant continues and `cnt` saturates at `MAX_HOLD`-1.
  - If the owner drops `req` in the same cycle that preemption would fire, treat it as a normal release (`preempt`=0).
- GAP:
  - Always lasts exactly one cycle, with `en`=0 and `grant`=0.
  - `sel` holds the previous owner.
  - Next state: any `req` set -> GRANT via arbitration (the old owner becomes lowest priority). Otherwise -> IDLE.
- `req` changes on non-owner lines during GRANT have no effect until the next arbitration.
- `grant` is never multi-hot. `grant` and `en` never change in the same cycle as `sel` while `en`=1.

## Timing
- Request to grant latency is 1 cycle: `req` sampled high at edge N in IDLE gives `en`=1 and `grant` valid after edge N.
- Owner release: `req[sel]` sampled low at edge N gives `en`=0 after edge N. The next grant appears after edge N+1 at the earliest.
- Preemption: `en` is high for exactly `MAX_HOLD` consecutive cycles, then 1 gap cycle.
- Fairness: under continuous full load, each requester waits at most 3×(`MAX_HOLD`+1) cycles.
- Reset is synchronous. `reset` sampled high at any edge, in any state, forces all reset values after that edge regardless of `req`. Arbitration resumes on the first edge with `reset`=0.
- All outputs are registered. There are no combinational paths from `req` to any output.

## Test plan
- Reset and idle: assert `reset` 2 cycles with `req`=4'b1111 -> `en`=0, `grant`=0, `sel`=0, `preempt`=0. Release `reset` -> `grant`=4'b0001 one cycle later.
- Single owner release: `req`=4'b0100 for 3 cycles, then 0 -> `grant`=4'b0100 for 3 cycles, then 1 GAP cycle, then IDLE. `preempt` never asserts.
- Round robin, `MAX_HOLD`=4, `req`=4'b1111 constant -> `grant` sequence is 0001, 0010, 0100, 1000, 0001. Each grant lasts 4 cycles, separated by 1 zero cycle, with `preempt`=1 in every gap.
- No contention: `MAX_HOLD`=4, `req`=4'b0010 for 10 cycles -> `grant`=4'b0010 continuously for 10 cycles with no preemption.
- Coincident drop and timeout: `MAX_HOLD`=4, `req`=4'b0011; requester 0 drops in its 4th cycle -> GAP with `preempt`=0, then `grant`=4'b0010.
- Mid-grant reset: during a `grant`=4'b1000 grant, pulse `reset` for 1 cycle with `req`=4'b1001 -> all outputs 0 after the edge. The next grant is 4'b0001 because `ptr` was reset to 3.
